// File: rtl/axis_frame_packer.sv
// Regenerates AXI4-Stream framing (tlast every N beats, tkeep all ones) behind the
// constant-adder stage, through a two-entry skid buffer with a registered output.
module axis_frame_packer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_BEAT_CNT_WIDTH   = 16,
    parameter int C_STAT_WIDTH       = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_aresetn,
    input  logic                            ctrl_enable,
    input  logic [C_BEAT_CNT_WIDTH-1:0]     ctrl_frame_beats,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_STAT_WIDTH-1:0]         stat_frames_done,
    output logic                            stat_busy
);

    localparam int KW = C_AXIS_TDATA_WIDTH / 8;

    logic                          m_valid_r;
    logic [C_AXIS_TDATA_WIDTH-1:0] m_data_r;
    logic                          m_last_r;
    logic                          sk_valid_r;
    logic [C_AXIS_TDATA_WIDTH-1:0] sk_data_r;
    logic                          sk_last_r;
    logic [C_BEAT_CNT_WIDTH-1:0]   beat_cnt_r;
    logic [C_BEAT_CNT_WIDTH-1:0]   frame_len_r;
    logic [C_STAT_WIDTH-1:0]       frames_done_r;

    logic                          ready_s;
    logic                          accept_s;
    logic                          xfer_s;
    logic                          first_beat_s;
    logic [C_BEAT_CNT_WIDTH-1:0]   len_in_s;
    logic [C_BEAT_CNT_WIDTH-1:0]   len_s;
    logic                          tag_last_s;

    // Handshake and framing decisions for the current cycle
    always_comb begin
        ready_s      = 1'b0;
        accept_s     = 1'b0;
        xfer_s       = 1'b0;
        first_beat_s = 1'b0;
        len_in_s     = ctrl_frame_beats;
        len_s        = frame_len_r;
        tag_last_s   = 1'b0;

        // Ready is forced low while reset is held so nothing upstream counts as accepted.
        if (axis_aresetn) begin
            ready_s = ctrl_enable & ~sk_valid_r;
        end else begin
            ready_s = 1'b0;
        end
        accept_s     = s_axis_tvalid & ready_s;
        xfer_s       = m_valid_r & m_axis_tready;
        first_beat_s = (beat_cnt_r == {C_BEAT_CNT_WIDTH{1'b0}});

        if (ctrl_frame_beats == {C_BEAT_CNT_WIDTH{1'b0}}) begin
            len_in_s = C_BEAT_CNT_WIDTH'(1);
        end else begin
            len_in_s = ctrl_frame_beats;
        end

        if (first_beat_s) begin
            len_s = len_in_s;
        end else begin
            len_s = frame_len_r;
        end
        tag_last_s = (beat_cnt_r == (len_s - C_BEAT_CNT_WIDTH'(1)));
    end

    // Skid buffer, beat counter and completed-frame counter
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_valid_r     <= 1'b0;
            m_data_r      <= {C_AXIS_TDATA_WIDTH{1'b0}};
            m_last_r      <= 1'b0;
            sk_valid_r    <= 1'b0;
            sk_data_r     <= {C_AXIS_TDATA_WIDTH{1'b0}};
            sk_last_r     <= 1'b0;
            beat_cnt_r    <= {C_BEAT_CNT_WIDTH{1'b0}};
            frame_len_r   <= {C_BEAT_CNT_WIDTH{1'b0}};
            frames_done_r <= {C_STAT_WIDTH{1'b0}};
        end else begin
            if (xfer_s && sk_valid_r) begin
                m_data_r   <= sk_data_r;
                m_last_r   <= sk_last_r;
                sk_valid_r <= accept_s;
                if (accept_s) begin
                    sk_data_r <= s_axis_tdata;
                    sk_last_r <= tag_last_s;
                end
            end else if (!m_valid_r || xfer_s) begin
                // Main is free (or freeing) with an empty skid: new beat lands in main.
                m_valid_r <= accept_s;
                if (accept_s) begin
                    m_data_r <= s_axis_tdata;
                    m_last_r <= tag_last_s;
                end
            end else if (accept_s) begin
                sk_valid_r <= 1'b1;
                sk_data_r  <= s_axis_tdata;
                sk_last_r  <= tag_last_s;
            end

            if (accept_s) begin
                if (first_beat_s) begin
                    frame_len_r <= len_in_s;
                end
                if (tag_last_s) begin
                    beat_cnt_r <= {C_BEAT_CNT_WIDTH{1'b0}};
                end else begin
                    beat_cnt_r <= beat_cnt_r + C_BEAT_CNT_WIDTH'(1);
                end
            end

            if (xfer_s && m_last_r) begin
                frames_done_r <= frames_done_r + C_STAT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready    = ready_s;
    assign m_axis_tvalid    = m_valid_r;
    assign m_axis_tdata     = m_data_r;
    assign m_axis_tlast     = m_last_r;
    assign m_axis_tkeep     = {KW{1'b1}};
    assign stat_frames_done = frames_done_r;
    assign stat_busy        = (beat_cnt_r != {C_BEAT_CNT_WIDTH{1'b0}}) | m_valid_r | sk_valid_r;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Directed bench for axis_frame_packer: framing, backpressure, length change,
// zero length, enable gap and asynchronous reset mid-frame.
module tb_axis_frame_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ctrl_enable = 1'b1;
    logic [15:0]  ctrl_frame_beats = 16'd4;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [511:0] s_tdata = 512'd0;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast;
    logic [31:0]  frames;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    bit acc;
    bit rdy_s;
    logic [511:0] q_data[$];
    bit           q_last[$];
    bit           stalled = 1'b0;
    logic [511:0] hold_data;
    logic         hold_last;
    logic [63:0]  keep_ones = '1;

    axis_frame_packer dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .ctrl_enable(ctrl_enable), .ctrl_frame_beats(ctrl_frame_beats),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .stat_frames_done(frames), .stat_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records transfers and checks that stalled outputs hold
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 512'(m_tvalid), 512'(1));
                check("hold_data", m_tdata, hold_data);
                check("hold_last", 512'(m_tlast), 512'(hold_last));
            end
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
            end
            stalled   = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_last = m_tlast;
        end
    end

    task automatic step();
        @(negedge clk);
        acc   = s_tvalid && s_tready;
        rdy_s = s_tready;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int first, input int n, input int chg_at,
                          input logic [15:0] new_len, input bit bp);
        int idx = 0;
        int c = 0;
        s_tvalid = 1'b1;
        s_tdata  = 512'(first);
        while (idx < n && c < 300) begin
            if (bp) m_tready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
            if (bp) check("bp_tready", 512'(rdy_s), 512'((c % 4) < 2));
            if (acc) begin
                idx++;
                if (idx == chg_at) ctrl_frame_beats = new_len;
            end
            s_tdata = 512'(first + idx);
            c++;
        end
        check("stream_done", 512'(idx), 512'(n));
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (6) step();
    endtask

    task automatic check_q(input string tag, input int first, input int n, input logic [31:0] exp_last);
        check({tag, "_count"}, 512'(q_data.size()), 512'(n));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            check({tag, "_data"}, q_data[i], 512'(first + i));
            check({tag, "_last"}, 512'(q_last[i]), 512'(exp_last[i]));
        end
        q_data.delete();
        q_last.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_tvalid", 512'(m_tvalid), 512'(0));
        check("rst_tlast", 512'(m_tlast), 512'(0));
        check("rst_tdata", m_tdata, 512'(0));
        check("rst_frames", 512'(frames), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_tready", 512'(s_tready), 512'(0));
        check("rst_tkeep", 512'(m_tkeep), 512'(keep_ones));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame length 4, 12 beats, no backpressure; first beat visible one edge later
        ctrl_frame_beats = 16'd4;
        s_tvalid = 1'b1;
        s_tdata  = 512'd0;
        step();
        check("lat_acc", 512'(acc), 512'(1));
        check("lat_tvalid", 512'(m_tvalid), 512'(1));
        check("lat_tdata", m_tdata, 512'(0));
        stream(1, 11, 0, 16'd0, 1'b0);
        drain();
        check_q("len4", 0, 12, 32'h888);
        check("len4_frames", 512'(frames), 512'(3));
        check("len4_busy", 512'(busy), 512'(0));
        check("len4_tkeep", 512'(m_tkeep), 512'(keep_ones));

        // Backpressure with tready pattern 1,0,0,1
        ctrl_frame_beats = 16'd3;
        stream(16'h100, 9, 0, 16'd0, 1'b1);
        drain();
        check_q("bp", 16'h100, 9, 32'h124);
        check("bp_frames", 512'(frames), 512'(6));

        // Length changed to 2 after beat 1 of a 5-beat frame
        ctrl_frame_beats = 16'd5;
        stream(16'h200, 9, 2, 16'd2, 1'b0);
        drain();
        check_q("chg", 16'h200, 9, 32'h150);
        check("chg_frames", 512'(frames), 512'(9));

        // Zero length behaves as one beat per frame
        ctrl_frame_beats = 16'd0;
        stream(16'h300, 3, 0, 16'd0, 1'b0);
        drain();
        check_q("zero", 16'h300, 3, 32'h7);
        check("zero_frames", 512'(frames), 512'(12));

        // Enable gap after two beats of a 4-beat frame
        ctrl_frame_beats = 16'd4;
        stream(16'h400, 2, 0, 16'd0, 1'b0);
        ctrl_enable = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 512'(16'h402);
        for (int g = 0; g < 5; g++) begin
            step();
            check("gap_tready", 512'(rdy_s), 512'(0));
        end
        s_tvalid = 1'b0;
        check("gap_busy", 512'(busy), 512'(1));
        check_q("gap_drain", 16'h400, 2, 32'h0);
        ctrl_enable = 1'b1;
        stream(16'h402, 2, 0, 16'd0, 1'b0);
        drain();
        check_q("gap_resume", 16'h402, 2, 32'h2);
        check("gap_frames", 512'(frames), 512'(13));

        // Asynchronous reset with one beat in main and one in skid
        m_tready = 1'b0;
        stream(16'h500, 2, 0, 16'd0, 1'b0);
        check("prerst_busy", 512'(busy), 512'(1));
        check("prerst_tready", 512'(s_tready), 512'(0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_tvalid", 512'(m_tvalid), 512'(0));
        check("arst_tdata", m_tdata, 512'(0));
        check("arst_frames", 512'(frames), 512'(0));
        check("arst_busy", 512'(busy), 512'(0));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_data.delete();
        q_last.delete();
        m_tready = 1'b1;
        stream(16'h600, 4, 0, 16'd0, 1'b0);
        drain();
        check_q("postrst", 16'h600, 4, 32'h8);
        check("postrst_frames", 512'(frames), 512'(1));
        check("postrst_busy", 512'(busy), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_frame_packer.md
Name: axis_frame_packer

Overview:
- Downstream stage of the constant-adder AXI4-Stream stage; consumes its m_axis output and feeds the DMA S2MM stream port.
- The adder leaves tlast/tkeep undriven, so this block regenerates framing: tlast on every Nth beat (N = FFT frame length in beats), tkeep all ones.
- Registered two-entry skid buffer gives full throughput with a registered output.
- Also provides a completed-frame counter for software status.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, data width of both stream interfaces; multiple of 8.
- C_BEAT_CNT_WIDTH, 16, width of the frame-length control input and the beat counter.
- C_STAT_WIDTH, 32, width of the completed-frame counter.

Ports:
- axis_aclk  in  1  single clock for both interfaces.
- axis_aresetn  in  1  asynchronous active-low reset.
- ctrl_enable  in  1  1 = accept input beats.
- ctrl_frame_beats  in  C_BEAT_CNT_WIDTH  beats per frame; sampled at frame start.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  upstream data.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  downstream data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
- m_axis_tlast  out  1  last beat of frame.
- stat_frames_done  out  C_STAT_WIDTH  frames fully sent downstream; wraps.
- stat_busy  out  1  frame in progress or data buffered.

Behaviour:
- Reset (axis_aresetn low, asynchronous): all storage is cleared. Outputs read m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, stat_frames_done=0, stat_busy=0. beat_cnt=0. s_axis_tready=0 while reset is asserted. Any buffered beats are discarded. Reset mid-frame restarts framing at beat 0.
- Storage: main register (m_valid, data, last) drives the m_axis outputs directly. Skid register (sk_valid, data, last) sits behind it.
- Handshakes:
  - s_axis_tready = ctrl_enable & ~sk_valid.
  - Input accept = s_axis_tvalid & s_axis_tready.
  - Output transfer = m_axis_tvalid & m_axis_tready.
- Accepted beat routing:
  - Goes into main if main is empty, or is transferring this cycle with skid empty.
  - Otherwise goes into skid.
  - When main transfers and skid is valid: main <= skid, skid is cleared, and a simultaneous accept goes into skid.
  - Order is preserved; no beat is dropped or duplicated.
- Latency: 1 cycle. A beat accepted at edge k is visible on m_axis at edge k if main was free.
- Throughput: sustained 1 beat/cycle while m_axis_tready=1.
- Framing:
  - tlast is computed at input acceptance and travels with the data.
  - On an accept with beat_cnt==0, frame_len is latched from ctrl_frame_beats. A value of 0 is treated as 1.
  - tag_last = (beat_cnt == len-1), where len is the value being latched on a first beat, else the stored frame_len.
  - beat_cnt <= tag_last ? 0 : beat_cnt+1.
  - Changing ctrl_frame_beats mid-frame has no effect until the next frame.
- m_axis_tkeep is always all ones, including while tvalid=0.
- stat_frames_done increments by 1 on each output transfer with m_axis_tlast=1. It wraps from all-ones to 0.
- stat_busy = (beat_cnt!=0) | m_valid | sk_valid.
- ctrl_enable low:
  - s_axis_tready drops in the same cycle.
  - Buffered beats still drain downstream.
  - beat_cnt is held, so the frame resumes where it stopped when ctrl_enable returns high.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable. m_axis_tvalid does not deassert until the transfer occurs.

Test Plan:
- Frame length and tlast: ctrl_frame_beats=4, 12 beats streamed with tdata=0..11 and m_axis_tready=1 → same data out in order. tlast on beats 3, 7, 11. stat_frames_done=3 and stat_busy=0 after drain.
- Backpressure: ctrl_frame_beats=3. m_axis_tready toggled 1,0,0,1 repeating while tvalid is held high for 9 beats. Required:
  - s_axis_tready falls only once the skid fills.
  - Output data is stable while stalled.
  - All 9 beats arrive in order, with tlast on beats 2, 5, 8.
- Frame length change: ctrl_frame_beats set to 2 after beat 1 of a frame with length 5 → that frame still ends on beat 4. The next frame ends after 2 beats.
- Length of zero: ctrl_frame_beats=0, 3 beats sent → every output beat has tlast=1 and stat_frames_done=3.
- Enable gap: ctrl_frame_beats=4. ctrl_enable is deasserted after 2 beats for 5 cycles, then reasserted. Required:
  - s_axis_tready=0 during the gap.
  - The 2 buffered beats drain.
  - After re-enable, tlast lands on the 4th beat overall.
- Reset mid-frame: axis_aresetn pulsed low asynchronously after beat 2 of a 4-beat frame, with data buffered → m_axis_tvalid=0 and counters=0 immediately. The next 4 beats form a complete frame with tlast on the 4th.
